// File: rtl/hyper_resp_pkg.sv
// Shared types for the HyperBus completion merger: FSM states, the descriptor record
// and the memory-select encoding that marks single-shot register accesses.
package hyper_resp_pkg;

    localparam logic [1:0] MEM_SEL_REG = 2'b01;

    // Descriptor field widths for the default configuration (ID_WIDTH=1, TRANS_SIZE=16)
    localparam int unsigned DESC_ID_W   = 2;
    localparam int unsigned DESC_SIZE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RESP
    } resp_state_e;

    typedef struct packed {
        logic [DESC_ID_W-1:0]   id;
        logic                   rw;
        logic                   single_shot;
        logic [DESC_SIZE_W-1:0] target;
    } desc_t;

    // Register-type memories, or any access to register space, complete with one sub-transaction
    function automatic logic is_single_shot(input logic addr_space, input logic [1:0] mem_sel);
        return (mem_sel == MEM_SEL_REG) | addr_space;
    endfunction

endpackage

// File: rtl/hyper_desc_fifo.sv
// Outstanding-descriptor queue: DEPTH entries of an arbitrary packed type with a registered
// occupancy count; the caller qualifies push/pop against full/empty.
module hyper_desc_fifo
    import hyper_resp_pkg::*;
#(
    parameter type         entry_t = desc_t,
    parameter int unsigned DEPTH   = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read once count says it was written.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/hyper_resp_merge.sv
// Merges per-sub-transaction completions from the HyperBus controller into one completion
// per original transaction, with overrun detection and an inactivity watchdog.
module hyper_resp_merge
    import hyper_resp_pkg::*;
#(
    parameter int unsigned TRANS_SIZE = 16,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  trans_valid_i,
    output logic                  trans_ready_o,
    input  logic [ID_WIDTH:0]     trans_id_i,
    input  logic                  trans_rw_i,
    input  logic                  trans_addr_space_i,
    input  logic [1:0]            trans_mem_sel_i,
    input  logic [TRANS_SIZE-1:0] trans_rx_size_i,
    input  logic [TRANS_SIZE-1:0] trans_tx_size_i,
    input  logic                  sub_valid_i,
    output logic                  sub_ready_o,
    input  logic [TRANS_SIZE-1:0] sub_len_i,
    input  logic                  sub_error_i,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic [ID_WIDTH:0]     done_trans_id_o,
    output logic                  done_rw_o,
    output logic [TRANS_SIZE-1:0] done_bytes_o,
    output logic                  done_error_o,
    output logic                  done_timeout_o,
    output logic                  busy_o
);

    localparam logic [ID_WIDTH:0] ID_NONE = {1'b1, {ID_WIDTH{1'b0}}};

    // Same fields as desc_t, sized for this instance
    typedef struct packed {
        logic [ID_WIDTH:0]     id;
        logic                  rw;
        logic                  single_shot;
        logic [TRANS_SIZE-1:0] target;
    } entry_t;

    entry_t      push_entry;
    entry_t      head_entry;
    entry_t      work_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    resp_state_e state_q;

    logic [TRANS_SIZE-1:0] acc_q;
    logic                  err_q;
    logic [TIMEOUT_W-1:0]  wdog_q;
    logic [TIMEOUT_W-1:0]  wdog_inc;
    logic [TRANS_SIZE:0]   sum;
    logic                  sub_fire;
    logic                  finish;
    logic                  overrun;

    assign push_entry = '{
        id:          trans_id_i,
        rw:          trans_rw_i,
        single_shot: is_single_shot(trans_addr_space_i, trans_mem_sel_i),
        target:      trans_rw_i ? trans_rx_size_i : trans_tx_size_i
    };

    assign trans_ready_o = !fifo_full;
    assign push          = trans_valid_i & trans_ready_o;
    assign pop           = (state_q == IDLE) & !fifo_empty;

    hyper_desc_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_desc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // One extra sum bit lets a final sub that overshoots the target saturate instead of wrapping
    assign sum      = {1'b0, acc_q} + {1'b0, sub_len_i};
    assign sub_fire = sub_valid_i & sub_ready_o;
    assign finish   = work_q.single_shot | (sum >= {1'b0, work_q.target}) | (work_q.target == '0);
    assign overrun  = (sum > {1'b0, work_q.target});
    assign wdog_inc = wdog_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            work_q          <= '0;
            acc_q           <= '0;
            err_q           <= 1'b0;
            wdog_q          <= '0;
            sub_ready_o     <= 1'b0;
            done_valid_o    <= 1'b0;
            done_trans_id_o <= ID_NONE;
            done_rw_o       <= 1'b0;
            done_bytes_o    <= '0;
            done_error_o    <= 1'b0;
            done_timeout_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        work_q      <= head_entry;
                        acc_q       <= '0;
                        err_q       <= 1'b0;
                        wdog_q      <= '0;
                        sub_ready_o <= 1'b1;
                        state_q     <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (sub_fire) begin
                        wdog_q <= '0;
                        if (finish) begin
                            sub_ready_o     <= 1'b0;
                            done_valid_o    <= 1'b1;
                            done_trans_id_o <= work_q.id;
                            done_rw_o       <= work_q.rw;
                            done_bytes_o    <= sum[TRANS_SIZE] ? '1 : sum[TRANS_SIZE-1:0];
                            done_error_o    <= err_q | sub_error_i | overrun;
                            done_timeout_o  <= 1'b0;
                            state_q         <= RESP;
                        end else begin
                            acc_q <= sum[TRANS_SIZE-1:0];
                            err_q <= err_q | sub_error_i;
                        end
                    end else if (wdog_inc == '1) begin
                        // Controller went silent: report what arrived so far as a failed completion
                        sub_ready_o     <= 1'b0;
                        done_valid_o    <= 1'b1;
                        done_trans_id_o <= work_q.id;
                        done_rw_o       <= work_q.rw;
                        done_bytes_o    <= acc_q;
                        done_error_o    <= 1'b1;
                        done_timeout_o  <= 1'b1;
                        state_q         <= RESP;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end

                RESP: begin
                    if (done_valid_o & done_ready_i) begin
                        done_valid_o    <= 1'b0;
                        done_trans_id_o <= ID_NONE;
                        done_rw_o       <= 1'b0;
                        done_bytes_o    <= '0;
                        done_error_o    <= 1'b0;
                        done_timeout_o  <= 1'b0;
                        state_q         <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = !fifo_empty | (state_q != IDLE);

endmodule
